// File: rtl/build_row_scan_if.sv
// Read channel between the row scanner (master) and the memory system (slave).
interface build_row_scan_if;
  logic        rd_rq_en_out;
  logic [47:0] rd_rq_addr_out;
  logic        rd_rq_afull_in;
  logic        rd_rs_en_in;
  logic [63:0] rd_rs_data_in;
  logic        rd_rs_afull_out;

  modport master (
    output rd_rq_en_out, rd_rq_addr_out, rd_rs_afull_out,
    input  rd_rq_afull_in, rd_rs_en_in, rd_rs_data_in
  );

  modport slave (
    input  rd_rq_en_out, rd_rq_addr_out, rd_rs_afull_out,
    output rd_rq_afull_in, rd_rs_en_in, rd_rs_data_in
  );
endinterface

// File: rtl/build_row_scan.sv
// Row scanner: issues strided reads, buffers in-order responses, filters rows by key.
// Key predicate enabled by macro BUILD_ROW_SCAN_PRED_EN; otherwise every row is emitted.
module build_row_scan #(
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned ADDR_STRIDE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [47:0]            row_base_addr_in,
  input  logic [63:0]            row_count_in,
  input  logic [31:0]            pred_lo_in,
  input  logic [31:0]            pred_hi_in,
  build_row_scan_if.master       rd,
  input  logic                   row_afull_in,
  output logic                   row_write_en_out,
  output logic [63:0]            row_value_out,
  output logic                   done,
  output logic [63:0]            rows_passed_out
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic          w_start_acc;
  logic [47:0]   r_addr;
  logic [63:0]   r_issued, r_count, r_rows_passed;
  logic [CW-1:0] r_outstanding, r_fifo_cnt;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [63:0]   r_mem [FIFO_DEPTH];
  logic          r_p1_valid, r_out_valid;
  logic [63:0]   r_p1_data, r_out_data;
  logic          w_room, w_rq_en, w_pop, w_fifo_empty, w_pass;

  // Credit check covers both in-flight reads and buffered rows, so the FIFO never overflows.
  assign w_room       = ({1'b0, r_outstanding} + {1'b0, r_fifo_cnt}) < (CW+1)'(FIFO_DEPTH);
  assign w_rq_en      = (r_state == SCAN) && (r_issued < r_count) && !rd.rd_rq_afull_in && w_room;
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_pop        = !w_fifo_empty && !row_afull_in;

`ifdef BUILD_ROW_SCAN_PRED_EN
  logic [31:0] r_pred_lo, r_pred_hi;
  assign w_pass = (r_p1_data[63:32] >= r_pred_lo) && (r_p1_data[63:32] <= r_pred_hi);
`else
  logic w_unused_pred;
  assign w_unused_pred = ^{pred_lo_in, pred_hi_in};
  assign w_pass        = 1'b1;
`endif

  assign rd.rd_rq_en_out    = w_rq_en;
  assign rd.rd_rq_addr_out  = r_addr;
  assign rd.rd_rs_afull_out = 1'b0;
  assign row_write_en_out   = r_out_valid;
  assign row_value_out      = r_out_data;
  assign done               = (r_state == DONE);
  assign rows_passed_out    = r_rows_passed;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_state_nxt = SCAN;
        w_start_acc = 1'b1;
      end
      SCAN:  if (r_issued == r_count) w_state_nxt = DRAIN;
      DRAIN: if (r_outstanding == '0 && w_fifo_empty && !r_p1_valid && !r_out_valid)
               w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rd.rd_rs_en_in) r_mem[r_wr_ptr] <= rd.rd_rs_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_issued      <= '0;
      r_count       <= '0;
      r_rows_passed <= '0;
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_p1_valid    <= 1'b0;
      r_p1_data     <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
`ifdef BUILD_ROW_SCAN_PRED_EN
      r_pred_lo     <= '0;
      r_pred_hi     <= '0;
`endif
    end else begin
      if (w_start_acc) begin
        r_addr        <= row_base_addr_in;
        r_issued      <= '0;
        r_count       <= row_count_in;
        r_rows_passed <= '0;
`ifdef BUILD_ROW_SCAN_PRED_EN
        r_pred_lo     <= pred_lo_in;
        r_pred_hi     <= pred_hi_in;
`endif
      end else begin
        if (w_rq_en) begin
          r_addr   <= r_addr + 48'(ADDR_STRIDE);
          r_issued <= r_issued + 64'd1;
        end
        if (r_out_valid) r_rows_passed <= r_rows_passed + 64'd1;
      end

      case ({w_rq_en, rd.rd_rs_en_in})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: ;
      endcase

      if (rd.rd_rs_en_in) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)          r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({rd.rd_rs_en_in, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: ;
      endcase

      // Stage 1 holds the popped row for evaluation; stage 2 is the emitted row.
      r_p1_valid <= w_pop;
      if (w_pop) r_p1_data <= r_mem[r_rd_ptr];
      r_out_valid <= r_p1_valid && w_pass;
      r_out_data  <= r_p1_data;
    end
  end
endmodule

// File: tb/tb_build_row_scan.sv
// Self-checking bench for build_row_scan: vector table, directed corner sequences, random scans.
`timescale 1ns/1ps
module tb_build_row_scan;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned STRIDE = 8;
`ifdef BUILD_ROW_SCAN_PRED_EN
  localparam bit PRED_ON = 1'b1;
`else
  localparam bit PRED_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, row_afull_in;
  logic [47:0] row_base_addr_in;
  logic [63:0] row_count_in;
  logic [31:0] pred_lo_in, pred_hi_in;
  logic        row_write_en_out, done;
  logic [63:0] row_value_out, rows_passed_out;
  logic        rs_en = 1'b0;
  logic [63:0] rs_data = '0;
  logic        rq_afull = 1'b0;

  build_row_scan_if rd_if();
  assign rd_if.rd_rs_en_in    = rs_en;
  assign rd_if.rd_rs_data_in  = rs_data;
  assign rd_if.rd_rq_afull_in = rq_afull;

  build_row_scan #(.FIFO_DEPTH(DEPTH), .ADDR_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .row_base_addr_in(row_base_addr_in), .row_count_in(row_count_in),
    .pred_lo_in(pred_lo_in), .pred_hi_in(pred_hi_in),
    .rd(rd_if.master), .row_afull_in(row_afull_in),
    .row_write_en_out(row_write_en_out), .row_value_out(row_value_out),
    .done(done), .rows_passed_out(rows_passed_out)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int cyc = 0;
  logic [47:0] g_base;
  logic [31:0] g_lo, g_hi;
  int g_lat, g_mode;
  logic [63:0] n_req;
  int n_emit, n_pass, n_emit_afull;

  typedef struct { int due; logic [63:0] data; } rsp_t;
  rsp_t        rsq[$];
  logic [63:0] expq[$];

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endfunction

  // Memory contents: row idx key in the upper word; mode 1 gives keys 5,10,15,...
  function automatic logic [63:0] row_data(input logic [63:0] idx, input int mode);
    logic [31:0] h, key;
    h = idx[31:0] * 32'h9E3779B1 + 32'h01234567;
    case (mode)
      1:       key = 32'd5 * (idx[31:0] + 32'd1);
      2:       key = {26'd0, h[31:26]};
      default: key = h;
    endcase
    return {key, h ^ 32'hC0FFEE00 ^ idx[31:0]};
  endfunction

  // Memory responder plus output scoreboard.
  always @(negedge clk) begin
    logic [63:0] d;
    logic [47:0] a;
    cyc++;
    if (rst) begin
      rsq.delete();
      expq.delete();
      rs_en = 1'b0;
    end else begin
      if (row_write_en_out) begin
        n_emit++;
        if (row_afull_in) n_emit_afull++;
        if (expq.size() == 0) begin
          checks++; errs++;
          $display("FAIL row_unexpected: got row 0x%0h, want no row", row_value_out);
        end else begin
          d = expq.pop_front();
          chk("row_value", row_value_out, d);
        end
      end
      if (rd_if.rd_rq_en_out) begin
        a = g_base + n_req[47:0] * 48'(STRIDE);
        chk("rq_addr", 64'(rd_if.rd_rq_addr_out), 64'(a));
        d = row_data(n_req, g_mode);
        rsq.push_back('{due: cyc + g_lat, data: d});
        if (!PRED_ON || (d[63:32] >= g_lo && d[63:32] <= g_hi)) begin
          expq.push_back(d);
          n_pass++;
        end
        n_req++;
      end
      if (rsq.size() > 0 && rsq[0].due <= cyc) begin
        rs_en   = 1'b1;
        rs_data = rsq[0].data;
        void'(rsq.pop_front());
      end else begin
        rs_en = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic begin_scan(input logic [47:0] base, input logic [63:0] count,
                            input logic [31:0] lo, input logic [31:0] hi,
                            input int lat, input int mode);
    g_base = base; g_lo = lo; g_hi = hi; g_lat = lat; g_mode = mode;
    n_req = '0; n_emit = 0; n_pass = 0; n_emit_afull = 0;
    row_base_addr_in = base; row_count_in = count;
    pred_lo_in = lo; pred_hi_in = hi;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit rnd);
    int k = 0;
    while (!done && k < budget) begin
      if (rnd) begin
        row_afull_in = ($urandom_range(0, 3) == 0);
        rq_afull     = ($urandom_range(0, 3) == 0);
      end
      tick();
      k++;
    end
    row_afull_in = 1'b0;
    rq_afull     = 1'b0;
    checks++;
    if (!done) begin
      errs++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, want done=1", name, budget);
    end
  endtask

  task automatic end_checks(input logic [63:0] count, input logic [63:0] exp_rows);
    tick();
    chk("req_count", n_req, count);
    chk("rows_left", 64'(expq.size()), 64'd0);
    chk("emit_vs_model", 64'(n_emit), 64'(n_pass));
    chk("emit_count", 64'(n_emit), exp_rows);
    chk("rows_passed", rows_passed_out, exp_rows);
    chk("done_hold", 64'(done), 64'd1);
    chk("rq_idle", 64'(rd_if.rd_rq_en_out), 64'd0);
  endtask

  typedef struct {
    logic [47:0] base; logic [63:0] count; logic [31:0] lo, hi;
    int lat, mode; logic [63:0] exp_on, exp_off;
  } vec_t;
  vec_t vecs[5];

  initial begin
    logic [63:0] cnt;
    vecs[0] = '{48'h1000,           64'd4,  32'd0,  32'hFFFFFFFF, 1, 0, 64'd4,  64'd4};
    vecs[1] = '{48'h2000,           64'd6,  32'd10, 32'd25,       1, 1, 64'd4,  64'd6};
    vecs[2] = '{48'h3000,           64'd5,  32'd20, 32'd10,       2, 1, 64'd0,  64'd5};
    vecs[3] = '{48'hFFFF_FFFF_FFF0, 64'd5,  32'd0,  32'hFFFFFFFF, 3, 0, 64'd5,  64'd5};
    vecs[4] = '{48'h4000,           64'd30, 32'd50, 32'd100,      4, 1, 64'd11, 64'd30};

    rst = 1'b1; start = 1'b0; row_afull_in = 1'b0;
    row_base_addr_in = '0; row_count_in = '0; pred_lo_in = '0; pred_hi_in = '0;
    g_base = '0; g_lo = '0; g_hi = '0; g_lat = 1; g_mode = 0; n_req = '0;
    n_emit = 0; n_pass = 0; n_emit_afull = 0;
    repeat (3) tick();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rq_en", 64'(rd_if.rd_rq_en_out), 64'd0);
    chk("rst_row_en", 64'(row_write_en_out), 64'd0);
    chk("rst_rows_passed", rows_passed_out, 64'd0);
    chk("rs_afull_tied", 64'(rd_if.rd_rs_afull_out), 64'd0);
    rst = 1'b0;
    tick();

    for (int unsigned i = 0; i < 5; i++) begin
      begin_scan(vecs[i].base, vecs[i].count, vecs[i].lo, vecs[i].hi, vecs[i].lat, vecs[i].mode);
      wait_done("vec", 500, 1'b0);
      end_checks(vecs[i].count, PRED_ON ? vecs[i].exp_on : vecs[i].exp_off);
    end

    // Zero-row scan: done three edges after the start edge, with no reads.
    begin_scan(48'h5000, 64'd0, 32'd0, 32'hFFFFFFFF, 1, 0);
    chk("zero_done_c1", 64'(done), 64'd0);
    tick();
    chk("zero_done_c2", 64'(done), 64'd0);
    tick();
    chk("zero_done_c3", 64'(done), 64'd1);
    chk("zero_reqs", n_req, 64'd0);
    chk("zero_rows", rows_passed_out, 64'd0);

    // Deep latency with a blocked consumer: in-flight plus buffered rows cap at DEPTH.
    row_afull_in = 1'b1;
    begin_scan(48'h10_0000, 64'd2000, 32'd0, 32'hFFFFFFFF, 100, 0);
    repeat (800) tick();
    chk("cap_inflight", n_req, 64'(DEPTH));
    chk("cap_no_emit", 64'(n_emit), 64'd0);
    row_afull_in = 1'b0;
    wait_done("deep", 6000, 1'b0);
    end_checks(64'd2000, 64'd2000);

    // Backpressure mid-scan: at most two rows slip through.
    begin_scan(48'h8000, 64'd40, 32'd0, 32'hFFFFFFFF, 1, 0);
    for (int k = 0; k < 200 && n_emit < 10; k++) tick();
    n_emit_afull = 0;
    row_afull_in = 1'b1;
    repeat (50) tick();
    row_afull_in = 1'b0;
    checks++;
    if (n_emit_afull > 2) begin
      errs++;
      $display("FAIL afull_slip: got %0d rows after afull, want <= 2", n_emit_afull);
    end
    wait_done("afull", 500, 1'b0);
    end_checks(64'd40, 64'd40);

    // Reset mid-scan, then a clean short scan.
    begin_scan(48'h9000, 64'd100, 32'd0, 32'hFFFFFFFF, 5, 0);
    repeat (20) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("mid_rst_rq_en", 64'(rd_if.rd_rq_en_out), 64'd0);
    chk("mid_rst_row_en", 64'(row_write_en_out), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_rows", rows_passed_out, 64'd0);
    rst = 1'b0;
    tick();
    begin_scan(48'hA000, 64'd3, 32'd0, 32'hFFFFFFFF, 2, 0);
    wait_done("post_rst", 500, 1'b0);
    end_checks(64'd3, 64'd3);

    for (int unsigned r = 0; r < 8; r++) begin
      cnt = 64'($urandom_range(1, 60));
      begin_scan(48'({$urandom, $urandom}), cnt, 32'($urandom_range(0, 63)),
                 32'($urandom_range(0, 63)), int'($urandom_range(1, 8)), 2);
      wait_done("rand", 3000, 1'b1);
      end_checks(cnt, 64'(n_pass));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/build_row_scan.md
BUILD_ROW_SCAN -- requirements
Module: build_row_scan

Interface
REQ-001 Parameter FIFO_DEPTH, default 512, meaning response buffer entries and the bound on in-flight reads; power of two, at least 8.
REQ-002 Parameter ADDR_STRIDE, default 8, meaning the byte distance between consecutive rows.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse that begins a scan.
REQ-006 row_base_addr_in  input  48  byte address of row 0, sampled on start.
REQ-007 row_count_in  input  64  number of rows to scan, sampled on start.
REQ-008 pred_lo_in / pred_hi_in  input  32 each  inclusive unsigned key bounds, sampled on start.
REQ-009 rd_rq_afull_in  input  1  read-request channel almost full.
REQ-010 rd_rq_en_out / rd_rq_addr_out  output  1 / 48  read-request valid and its byte address.
REQ-011 rd_rs_en_in / rd_rs_data_in  input  1 / 64  in-order read-response valid and its row data.
REQ-012 row_afull_in  input  1  downstream build stage almost full.
REQ-013 row_write_en_out / row_value_out  output  1 / 64  qualifying row valid and its value.
REQ-014 done  output  1  scan complete; held high until the next start.
REQ-015 rows_passed_out  output  64  count of rows emitted in the current scan.

Function
REQ-016 The FSM SHALL use states IDLE, SCAN, DRAIN and DONE; reset enters IDLE.
REQ-017 State transitions SHALL be:
- IDLE -> SCAN on start.
- SCAN -> DRAIN when issued == row_count.
- DRAIN -> DONE when outstanding == 0, the FIFO is empty and the pipeline is empty.
- DONE -> SCAN on start.
REQ-018 A start pulse seen in SCAN or DRAIN SHALL be ignored.
REQ-019 In SCAN, rd_rq_en_out SHALL be 1 exactly when all of the following hold:
- issued < row_count;
- rd_rq_afull_in is 0;
- outstanding + fifo_count < FIFO_DEPTH.
REQ-020 rd_rq_addr_out SHALL equal base + issued*ADDR_STRIDE, truncated to 48 bits; wrap-around is silent.
REQ-021 The outstanding counter SHALL increment on a request and decrement on rd_rs_en_in; when both occur in the same cycle it SHALL stay unchanged.
REQ-022 Every response SHALL be written into the FIFO; overflow is impossible by REQ-019, and rd_rs_afull_out is tied to 0.
REQ-023 The FIFO SHALL be popped when it is not empty and row_afull_in is 0.
REQ-024 The popped row SHALL be registered for one cycle of predicate evaluation.
REQ-025 A popped row SHALL be emitted on the next cycle when pred_lo <= data[63:32] <= pred_hi; pop-to-emit latency is 2 clk.
REQ-026 Rows failing the predicate SHALL be dropped silently.
REQ-027 If pred_lo > pred_hi, no row SHALL be emitted, but the scan SHALL still complete.
REQ-028 rows_passed_out SHALL increment on each row_write_en_out and clear on start.
REQ-029 When row_count == 0, the FSM SHALL pass through SCAN and DRAIN with no requests, and done SHALL rise 3 cycles after start.
REQ-030 Emitted row order SHALL equal address order.
REQ-031 A row popped before row_afull_in rises SHALL still be emitted; row_afull_in is honoured at pop time only, giving 2 cycles of slip.

Reset
REQ-032 rst SHALL force the following, overriding start in the same cycle:
- state IDLE;
- issued, outstanding and rows_passed to 0;
- FIFO empty and pipeline valid bits to 0;
- rd_rq_en_out, row_write_en_out and done to 0.
REQ-033 Reset during SCAN SHALL abandon in-flight reads; the bench must not drive responses after reset.

Configuration
REQ-034 With macro BUILD_ROW_SCAN_PRED_EN defined, the predicate of REQ-025 SHALL be applied.
REQ-035 With the macro undefined, pred_lo_in and pred_hi_in SHALL be ignored and every row emitted, with the same 2-cycle latency.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Scenario 1: base=0x1000, count=4, bounds [0, 0xFFFFFFFF], memory returns 1 cycle later. Required: addresses 0x1000, 0x1008, 0x1010, 0x1018; 4 rows emitted in order; rows_passed=4; done high.
- Scenario 2: count=6 with keys 5,10,15,20,25,30 and bounds [10,25]. Required: rows with keys 10, 15, 20 and 25 are emitted; rows_passed=4. With the macro off, all 6 are emitted.
- Scenario 3: count=2000, response latency 100 cycles. Required: outstanding+fifo never exceeds 512; all 2000 rows are emitted; no loss.
- Scenario 4: row_afull_in held high for 50 cycles mid-scan. Required: at most 2 rows are emitted after it rises; the scan completes with the correct count.
- Scenario 5: start with count=0. Required: no requests; done=1 at cycle 3.
- Scenario 6: rst asserted mid-SCAN, then a new start with count=3. Required: all outputs 0 after reset; the second scan emits exactly 3 rows.
